wino_layer_scheduler: RTL and testbench
=======================================

// Module: wino_layer_scheduler
// PURPOSE
//  Sequences one Winograd conv layer through data_controller: computes tile-grid size, broadcasts config,
//  steps input_id across channels, issues input_prepare, waits loop_finished, drains transform pipeline.
//  Sits between host/top-level start interface and data_controller; flags tile-valid to PE arrays.
// PARAMETERS
//  ID_W      4  width of input_id_o; max channels = 2**ID_W
//  DIM_W     8  width of feature-map/block dimensions
//  PIPE_LAT  2  cycles from accepted input_valid_i to transformed tile at result_tile_o_*
// PORTS
//  clk              in   1      rising-edge clock (single clock domain)
//  reset            in   1      asynchronous, active-high reset
//  start_i          in   1      pulse: begin layer, samples cfg inputs this cycle
//  abort_i          in   1      sync abort, return to IDLE
//  total_id_i       in   8      number of input channels (ids) in layer
//  size_type_i      in   1      0: F(4,3) stride 4; 1: F(2,5) stride 2
//  input_length_i   in   DIM_W  feature-map height
//  input_width_i    in   DIM_W  feature-map width
//  pe_ready_i       in   1      PE arrays may accept next channel
//  loop_finished_i  in   1      from data_controller: current id's blocks issued
//  input_valid_i    in   1      memory returned tile pair this cycle
//  wen_o            out  1      1-cycle config broadcast to data_controller
//  input_id_o       out  ID_W   current channel id
//  input_prepare_o  out  1      1-cycle pulse: fetch next id
//  block_width_o    out  DIM_W  tiles per row
//  block_height_o   out  DIM_W  tiles per column
//  tile_valid_o     out  1      result_tile_o_* valid this cycle
//  busy_o           out  1      state != IDLE
//  done_o           out  1      1-cycle pulse, layer complete
//  cfg_err_o        out  1      1-cycle pulse, start rejected
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; delay line cleared; cfg regs 0.
//  Block dims (registered on start): type0: (d+1)>>2; type1: (d-3)>>1, d = length/width.
//  Reject (cfg_err_o pulse next cycle, stay IDLE) if total_id_i==0, total_id_i>2**ID_W,
//   type0 and d<6, type1 and d<6 (either dimension).
//  FSM:
//   IDLE    : start_i & valid cfg -> CONFIG, wen_o=1 next cycle.
//   CONFIG  : 1 cycle; input_id_o=0 -> PREPARE.
//   PREPARE : when pe_ready_i: input_prepare_o=1 for one cycle -> STREAM; else hold, no pulse.
//   STREAM  : on loop_finished_i: id==total_id-1 -> DRAIN; else id+1 -> PREPARE.
//   DRAIN   : count PIPE_LAT+1 cycles -> DONE.
//   DONE    : done_o=1 one cycle -> IDLE.
//  block_width_o/block_height_o stable from CONFIG until next accepted start.
//  input_id_o changes only on STREAM->PREPARE; holds in DONE/IDLE until next CONFIG.
//  tile_valid_o = input_valid_i delayed PIPE_LAT cycles, gated by busy at ingress; flushes in DRAIN.
//  loop_finished_i outside STREAM: ignored. start_i while busy: ignored (no error).
//  abort_i any state: next cycle IDLE, prepare/wen/done 0, delay line cleared; abort beats start same cycle.
//  Async reset mid-layer: immediate IDLE, outputs 0, no done_o.
//  id counter never wraps: DRAIN entry is on id==total_id-1 compare.
// STRUCTURE
//  wino_pkg: state enum (IDLE,CONFIG,PREPARE,STREAM,DRAIN,DONE), TILE_IN=6, STRIDE_F43=4,
//   STRIDE_F25=2, MIN_DIM=6.
//  Sub-module wino_valid_delay #(LAT) (clk, reset, clr, d, q): shift-register valid pipe.
//  Top: cfg regs + dim calc, FSM, id counter, drain counter.
// TESTING
//  T1 start, total_id=2, type0, 10x10, pe_ready=1 -> wen pulse; block 2x2; prepare id0, LF -> prepare id1, LF -> done after PIPE_LAT+1+1 cycles.
//  T2 total_id=0 or width=5 -> cfg_err_o one pulse, busy_o stays 0, no wen_o.
//  T3 type1, 11x9 -> block_width=3, block_height=4.
//  T4 pe_ready=0 for 5 cycles in PREPARE -> no prepare pulse; pulse exactly 1 cycle after pe_ready rises.
//  T5 input_valid_i at cycle n -> tile_valid_o at n+2 (PIPE_LAT=2); back-to-back valids preserved.
//  T6 abort_i during STREAM with same-cycle start_i -> IDLE next cycle, no done_o; async reset mid-DRAIN -> outputs 0 at once.

Source files
------------

// File: rtl/wino_pkg.sv
// Shared state encoding, Winograd tiling constants and the tile-count helper
// used by the layer scheduler.
package wino_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONFIG  = 3'd1,
    S_PREPARE = 3'd2,
    S_STREAM  = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int TILE_IN    = 6;
  localparam int STRIDE_F43 = 4;
  localparam int STRIDE_F25 = 2;
  localparam int MIN_DIM    = 6;

  // Tiles along one axis: ceil((d - overlap) / stride), overlap = TILE_IN - stride.
  // Gives (d+1)>>2 for F(4,3) and (d-3)>>1 for F(2,5).
  function automatic int tiles(input int d, input int stride);
    return (d - TILE_IN + 2 * stride - 1) / stride;
  endfunction

endpackage

// File: rtl/wino_valid_delay.sv
// Shift-register valid pipe: q is d delayed LAT cycles; clr empties the pipe.
module wino_valid_delay #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [LAT-1:0] sr_q;
  logic [LAT-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (clr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[LAT-1];

endmodule

// File: rtl/wino_layer_scheduler.sv
// Sequences one Winograd conv layer: validates and latches config, steps the
// channel id through prepare/stream rounds, then drains the transform pipe.
module wino_layer_scheduler
  import wino_pkg::*;
#(
  parameter int ID_W     = 4,
  parameter int DIM_W    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [7:0]       total_id_i,
  input  logic             size_type_i,
  input  logic [DIM_W-1:0] input_length_i,
  input  logic [DIM_W-1:0] input_width_i,
  input  logic             pe_ready_i,
  input  logic             loop_finished_i,
  input  logic             input_valid_i,
  output logic             wen_o,
  output logic [ID_W-1:0]  input_id_o,
  output logic             input_prepare_o,
  output logic [DIM_W-1:0] block_width_o,
  output logic [DIM_W-1:0] block_height_o,
  output logic             tile_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic [2:0]       state_o
);

  // Handshake: input_prepare_o is a single-cycle request; the data_controller
  // answers with a single-cycle loop_finished_i, honoured only in STREAM.

  localparam int DRW = $clog2(PIPE_LAT + 2);

  state_t           state_q, state_d;
  logic [7:0]       total_q;
  logic [DIM_W-1:0] blk_w_q, blk_w_d;
  logic [DIM_W-1:0] blk_h_q, blk_h_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic             prepare_q, prepare_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ok, start_acc, accept, last_id;
  int               stride;

  assign cfg_ok = (total_id_i != 8'd0) &&
                  (int'(total_id_i) <= (1 << ID_W)) &&
                  (int'(input_length_i) >= MIN_DIM) &&
                  (int'(input_width_i) >= MIN_DIM);

  // Abort wins over a same-cycle start; start while busy is silently dropped.
  assign start_acc = start_i && !abort_i && (state_q == S_IDLE);
  assign accept    = start_acc && cfg_ok;
  assign cfg_err_d = start_acc && !cfg_ok;
  assign last_id   = (int'(id_q) == int'(total_q) - 1);

  always_comb begin
    stride  = size_type_i ? STRIDE_F25 : STRIDE_F43;
    blk_w_d = blk_w_q;
    blk_h_d = blk_h_q;
    if (accept) begin
      blk_w_d = DIM_W'(tiles(int'(input_width_i), stride));
      blk_h_d = DIM_W'(tiles(int'(input_length_i), stride));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (accept) state_d = S_CONFIG;
        S_CONFIG:  state_d = S_PREPARE;
        S_PREPARE: if (pe_ready_i) state_d = S_STREAM;
        S_STREAM:  if (loop_finished_i) state_d = last_id ? S_DRAIN : S_PREPARE;
        S_DRAIN:   if (drain_q == DRW'(PIPE_LAT)) state_d = S_DONE;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wen_o     = (state_q == S_CONFIG);
    done_o    = (state_q == S_DONE);
    busy_o    = (state_q != S_IDLE);
    prepare_d = (state_q == S_PREPARE) && pe_ready_i && !abort_i;
  end

  always_comb begin
    id_d    = id_q;
    drain_d = '0;
    if (state_q == S_CONFIG) begin
      id_d = '0;
    end else if ((state_q == S_STREAM) && loop_finished_i && !last_id && !abort_i) begin
      id_d = id_q + ID_W'(1);
    end
    if (state_q == S_DRAIN) begin
      drain_d = drain_q + DRW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q   <= '0;
      blk_w_q   <= '0;
      blk_h_q   <= '0;
      id_q      <= '0;
      drain_q   <= '0;
      prepare_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      if (accept) begin
        total_q <= total_id_i;
      end
      blk_w_q   <= blk_w_d;
      blk_h_q   <= blk_h_d;
      id_q      <= id_d;
      drain_q   <= drain_d;
      prepare_q <= prepare_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  wino_valid_delay #(.LAT(PIPE_LAT)) u_valid_delay (
    .clk   (clk),
    .reset (reset),
    .clr   (abort_i),
    .d     (input_valid_i && busy_o),
    .q     (tile_valid_o)
  );

  assign input_id_o      = id_q;
  assign input_prepare_o = prepare_q;
  assign block_width_o   = blk_w_q;
  assign block_height_o  = blk_h_q;
  assign cfg_err_o       = cfg_err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_wino_layer_scheduler.sv
// Directed bench for wino_layer_scheduler with a scoreboard for tile-valid
// arrival cycles and the channel id carried by each prepare pulse.
module tb_wino_layer_scheduler;

  localparam int ID_W     = 4;
  localparam int DIM_W    = 8;
  localparam int PIPE_LAT = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_i, abort_i, size_type_i;
  logic [7:0]       total_id_i;
  logic [DIM_W-1:0] input_length_i, input_width_i;
  logic             pe_ready_i, loop_finished_i, input_valid_i;
  logic             wen_o, input_prepare_o, tile_valid_o, busy_o, done_o, cfg_err_o;
  logic [ID_W-1:0]  input_id_o;
  logic [DIM_W-1:0] block_width_o, block_height_o;
  logic [2:0]       state_o;

  int          cyc = 0;
  int          tot_cnt = 0;
  int          fail_cnt = 0;
  int          n;
  bit          mon_en = 1'b0;
  logic        exp_tv;
  logic [31:0] exp_q[$];
  logic [31:0] id_q[$];

  logic [7:0]       bad_t[3];
  logic [DIM_W-1:0] bad_w[3];
  logic             vpat[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wino_layer_scheduler #(.ID_W(ID_W), .DIM_W(DIM_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .total_id_i      (total_id_i),
    .size_type_i     (size_type_i),
    .input_length_i  (input_length_i),
    .input_width_i   (input_width_i),
    .pe_ready_i      (pe_ready_i),
    .loop_finished_i (loop_finished_i),
    .input_valid_i   (input_valid_i),
    .wen_o           (wen_o),
    .input_id_o      (input_id_o),
    .input_prepare_o (input_prepare_o),
    .block_width_o   (block_width_o),
    .block_height_o  (block_height_o),
    .tile_valid_o    (tile_valid_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .cfg_err_o       (cfg_err_o),
    .state_o         (state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tot_cnt++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_valid();
    input_valid_i = 1'b1;
    exp_q.push_back(32'(cyc + PIPE_LAT));
  endtask

  // Pulse loop_finished_i and count cycles until done_o, bounded.
  task automatic lf_to_done(output int cnt);
    loop_finished_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      loop_finished_i = 1'b0;
      cnt++;
      if (done_o) break;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_tv = (exp_q.size() > 0) && (exp_q[0] == 32'(cyc));
      check("tile_valid", {31'd0, tile_valid_o}, {31'd0, exp_tv});
      if (exp_tv) void'(exp_q.pop_front());
      if (input_prepare_o) begin
        if (id_q.size() > 0) check("prep_id", {28'd0, input_id_o}, id_q.pop_front());
        else check("prep_unexpected", {31'd0, input_prepare_o}, 32'd0);
      end
    end
  end

  initial begin
    bad_t = '{8'd0, 8'd2, 8'd17};
    bad_w = '{8'd10, 8'd5, 8'd10};
    vpat  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    reset = 1'b1; start_i = 0; abort_i = 0; size_type_i = 0; total_id_i = 0;
    input_length_i = 0; input_width_i = 0; pe_ready_i = 0; loop_finished_i = 0;
    input_valid_i = 0;
    repeat (2) tick();
    check("rst_busy", busy_o, 0);
    check("rst_wen", wen_o, 0);
    check("rst_done", done_o, 0);
    check("rst_cfg_err", cfg_err_o, 0);
    check("rst_id", input_id_o, 0);
    check("rst_bw", block_width_o, 0);
    check("rst_tile", tile_valid_o, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // T1: two channels, F(4,3), 10x10
    total_id_i = 2; size_type_i = 0; input_length_i = 10; input_width_i = 10;
    pe_ready_i = 1; start_i = 1;
    id_q.push_back(0); id_q.push_back(1);
    tick(); start_i = 0;
    check("t1_wen", wen_o, 1);
    check("t1_busy", busy_o, 1);
    check("t1_bw", block_width_o, 2);
    check("t1_bh", block_height_o, 2);
    check("t1_id0", input_id_o, 0);
    tick();
    check("t1_wen_off", wen_o, 0);
    tick();
    check("t1_prep0", input_prepare_o, 1);
    push_valid();
    tick(); input_valid_i = 0;
    check("t1_prep0_off", input_prepare_o, 0);
    loop_finished_i = 1;
    tick(); loop_finished_i = 0;
    check("t1_id1", input_id_o, 1);
    tick();
    check("t1_prep1", input_prepare_o, 1);
    lf_to_done(n);
    check("t1_done_lat", n, PIPE_LAT + 2);
    tick();
    check("t1_done_off", done_o, 0);
    check("t1_idle", busy_o, 0);
    check("t1_id_hold", input_id_o, 1);
    // valid while idle must be gated
    input_valid_i = 1;
    tick(); input_valid_i = 0;
    repeat (3) tick();

    // T2: rejected configurations
    for (int k = 0; k < 3; k++) begin
      total_id_i = bad_t[k]; input_width_i = bad_w[k]; input_length_i = 10; start_i = 1;
      tick(); start_i = 0;
      check("t2_err", cfg_err_o, 1);
      check("t2_busy", busy_o, 0);
      check("t2_wen", wen_o, 0);
      tick();
      check("t2_err_off", cfg_err_o, 0);
      check("t2_busy2", busy_o, 0);
      check("t2_bw_keep", block_width_o, 2);
    end

    // T3/T4/T5: F(2,5) 11x9, pe_ready gating, valid pipeline
    total_id_i = 1; size_type_i = 1; input_length_i = 11; input_width_i = 9;
    pe_ready_i = 0; start_i = 1;
    tick(); start_i = 0;
    check("t3_wen", wen_o, 1);
    check("t3_bw", block_width_o, 3);
    check("t3_bh", block_height_o, 4);
    tick();
    for (int k = 0; k < 5; k++) begin
      loop_finished_i = (k == 0);
      start_i = (k == 1);
      total_id_i = (k == 1) ? 8'd0 : 8'd1;
      tick();
      check("t4_no_prep", input_prepare_o, 0);
      check("t4_busy", busy_o, 1);
      check("t4_no_err", cfg_err_o, 0);
    end
    loop_finished_i = 0; start_i = 0; total_id_i = 1;
    id_q.push_back(0);
    pe_ready_i = 1;
    tick();
    check("t4_prep", input_prepare_o, 1);
    for (int k = 0; k < 5; k++) begin
      if (vpat[k]) push_valid();
      else input_valid_i = 0;
      tick();
    end
    input_valid_i = 0;
    check("t4_prep_off", input_prepare_o, 0);
    repeat (2) tick();
    lf_to_done(n);
    check("t3_done_lat", n, PIPE_LAT + 2);
    tick();
    check("t3_idle", busy_o, 0);
    check("t3_bw_keep", block_width_o, 3);
    check("t3_id_hold", input_id_o, 0);

    // T6a: abort in STREAM beats same-cycle start; 16 channels is legal
    total_id_i = 16; size_type_i = 0; input_length_i = 16; input_width_i = 16;
    pe_ready_i = 1; start_i = 1;
    id_q.push_back(0); id_q.push_back(1);
    tick(); start_i = 0;
    check("t6_busy", busy_o, 1);
    check("t6_bw", block_width_o, 4);
    repeat (2) tick();
    loop_finished_i = 1;
    tick(); loop_finished_i = 0;
    tick();
    input_valid_i = 1;
    tick(); input_valid_i = 0;
    abort_i = 1; start_i = 1;
    tick(); abort_i = 0; start_i = 0;
    check("t6_abort_busy", busy_o, 0);
    check("t6_abort_wen", wen_o, 0);
    check("t6_abort_done", done_o, 0);
    check("t6_abort_prep", input_prepare_o, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_stay_idle", busy_o, 0);
      check("t6_no_done", done_o, 0);
    end

    // T6b: async reset mid-DRAIN, minimum 6x6 map
    total_id_i = 1; input_length_i = 6; input_width_i = 6; start_i = 1;
    id_q.push_back(0);
    tick(); start_i = 0;
    check("t6_bw_min", block_width_o, 1);
    repeat (2) tick();
    loop_finished_i = 1;
    tick(); loop_finished_i = 0;
    tick();
    check("t6_in_drain", busy_o, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_done", done_o, 0);
    check("t6_rst_bw", block_width_o, 0);
    check("t6_rst_state", state_o, 0);
    tick(); reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_post_rst_done", done_o, 0);
    end

    check("sb_tile_empty", exp_q.size(), 0);
    check("sb_id_empty", id_q.size(), 0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", tot_cnt - fail_cnt, tot_cnt);
    $finish;
  end

endmodule
